// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared FSM states, wait-counter width and helpers for sram_bank_ctrl
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE,
    CLEAR
  } state_t;

  localparam int CNT_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - single-port byte-enable RAM bank with registered, read-enabled output
module sram_bank #(
  parameter int DW      = 16,
  parameter int BANK_AW = 16
) (
  input  logic                 clk_p,
  input  logic                 rden,
  input  logic                 wren,
  input  logic [DW/8-1:0]      be,
  input  logic [BANK_AW-1:0]   addr,
  input  logic [DW-1:0]        d,
  output logic [DW-1:0]        q
);

  logic [DW-1:0] mem [2**BANK_AW];

  always_ff @(posedge clk_p) begin
    if (wren) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
      end
    end
    if (rden) q <= mem[addr];
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - SDRAM-style host port over NBANKS RAM banks; SRAM_INIT_CLEAR_EN adds post-reset clear
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 21,
  parameter int BANK_AW = 16,
  parameter int NBANKS  = 5,
  parameter int RD_WAIT = 0,
  parameter int WR_WAIT = 0
) (
  input  logic              clk_p,
  input  logic              sdram_reset_n,
  input  logic              sdram_stb,
  input  logic              sdram_we,
  input  logic [DW/8-1:0]   sdram_sel,
  input  logic [AW:1]       sdram_adr,
  input  logic [DW-1:0]     sdram_out,
  output logic              sdram_ack,
  output logic [DW-1:0]     sdram_dat,
  output logic              sdram_ready,
  output logic              sdram_err
);

  localparam int NB  = DW / 8;
  localparam int BIW = AW - BANK_AW;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_r;
  logic [NB-1:0]      sel_r;
  logic [AW:1]        adr_r;
  logic [DW-1:0]      wdat_r;
  logic               oor_r;
  logic [NBANKS-1:0]  bank_oh;
  logic               ack_r;
  logic               err_r;
  logic               ready_r;
  logic [DW-1:0]      dat_r;
`ifdef SRAM_INIT_CLEAR_EN
  logic [BANK_AW-1:0] clr_addr;
`endif

  logic [BIW-1:0]     bank_idx;
  logic [NBANKS-1:0]  ram_rden;
  logic [NBANKS-1:0]  ram_wren;
  logic [NB-1:0]      ram_be;
  logic [BANK_AW-1:0] ram_addr;
  logic [DW-1:0]      ram_d;
  logic [DW-1:0]      ram_q [NBANKS];
  logic [DW-1:0]      rd_val;

  assign bank_idx    = sdram_adr[AW:BANK_AW+1];
  assign sdram_ack   = ack_r & sdram_stb;
  assign sdram_dat   = dat_r;
  assign sdram_err   = err_r;
  assign sdram_ready = ready_r;

  always_comb begin
    ram_addr = adr_r[BANK_AW:1];
    ram_be   = sel_r;
    ram_d    = wdat_r;
    for (int i = 0; i < NBANKS; i++) begin
      ram_wren[i] = (state == ACCESS) && we_r && bank_oh[i];
      ram_rden[i] = (state == ACCESS) && !we_r && bank_oh[i];
    end
`ifdef SRAM_INIT_CLEAR_EN
    // Reset parks the FSM in CLEAR, so the write enable must also see reset.
    if (state == CLEAR) begin
      ram_addr = clr_addr;
      ram_be   = '1;
      ram_d    = '0;
      ram_wren = {NBANKS{sdram_reset_n}};
    end
`endif
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    sram_bank #(.DW(DW), .BANK_AW(BANK_AW)) u_bank (
      .clk_p (clk_p),
      .rden  (ram_rden[g]),
      .wren  (ram_wren[g]),
      .be    (ram_be),
      .addr  (ram_addr),
      .d     (ram_d),
      .q     (ram_q[g])
    );
  end

  // An out-of-range access has an all-zero select, so its read returns 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NBANKS; i++) rd_val = rd_val | (ram_q[i] & {DW{bank_oh[i]}});
  end

  always_ff @(posedge clk_p or negedge sdram_reset_n) begin
    if (!sdram_reset_n) begin
`ifdef SRAM_INIT_CLEAR_EN
      state    <= CLEAR;
      clr_addr <= '0;
`else
      state    <= IDLE;
`endif
      cnt      <= '0;
      we_r     <= 1'b0;
      sel_r    <= '0;
      adr_r    <= '0;
      wdat_r   <= '0;
      oor_r    <= 1'b0;
      bank_oh  <= '0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      ready_r  <= 1'b0;
      dat_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_r <= 1'b1;
          if (sdram_stb && ready_r) begin
            we_r   <= sdram_we;
            sel_r  <= sdram_sel;
            adr_r  <= sdram_adr;
            wdat_r <= sdram_out;
            oor_r  <= int'(bank_idx) >= NBANKS;
            for (int i = 0; i < NBANKS; i++) bank_oh[i] <= (int'(bank_idx) == i);
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if ((we_r ? WR_WAIT : RD_WAIT) > 0) begin
            cnt   <= we_r ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
            state <= WAIT;
          end else begin
            state <= DONE;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          // ack_r doubles as the "already captured" flag while stb is held.
          if (!sdram_stb) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            state <= IDLE;
          end else if (!ack_r) begin
            ack_r <= 1'b1;
            err_r <= oor_r;
            if (!we_r) dat_r <= rd_val;
          end
        end
`ifdef SRAM_INIT_CLEAR_EN
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            ready_r <= 1'b1;
            state   <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - randomized self-checking bench for sram_bank_ctrl, zero-wait and waited instances in lockstep
module tb_sram_bank_ctrl;

  localparam int DW      = 16;
  localparam int AW      = 21;
  localparam int BANK_AW = 16;
  localparam int NBANKS  = 5;
  localparam int RW1     = 3;
  localparam int WW1     = 2;

  logic          clk_p = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb   = 1'b0;
  logic          we    = 1'b0;
  logic [1:0]    sel   = '0;
  logic [AW:1]   adr   = '0;
  logic [DW-1:0] wdat  = '0;
  logic          ack0, ack1, rdy0, rdy1, err0, err1;
  logic [DW-1:0] dat0, dat1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [int];
  logic [DW-1:0] last_rd = '0;

  always #5 clk_p = ~clk_p;

  sram_bank_ctrl #(.DW(DW), .AW(AW), .BANK_AW(BANK_AW), .NBANKS(NBANKS),
                   .RD_WAIT(0), .WR_WAIT(0)) u_dut0 (
    .clk_p(clk_p), .sdram_reset_n(rst_n), .sdram_stb(stb), .sdram_we(we),
    .sdram_sel(sel), .sdram_adr(adr), .sdram_out(wdat), .sdram_ack(ack0),
    .sdram_dat(dat0), .sdram_ready(rdy0), .sdram_err(err0));

  sram_bank_ctrl #(.DW(DW), .AW(AW), .BANK_AW(BANK_AW), .NBANKS(NBANKS),
                   .RD_WAIT(RW1), .WR_WAIT(WW1)) u_dut1 (
    .clk_p(clk_p), .sdram_reset_n(rst_n), .sdram_stb(stb), .sdram_we(we),
    .sdram_sel(sel), .sdram_adr(adr), .sdram_out(wdat), .sdram_ack(ack1),
    .sdram_dat(dat1), .sdram_ready(rdy1), .sdram_err(err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(rdy0 && rdy1) && n < 70000) begin
      @(negedge clk_p);
      n++;
    end
`ifdef SRAM_INIT_CLEAR_EN
    check({tag, ".ready_lat"}, n, 1 << BANK_AW);
`else
    check({tag, ".ready_lat"}, n, 1);
`endif
  endtask

  task automatic txn(input bit w, input logic [20:0] a, input logic [1:0] s,
                     input logic [15:0] d, input string tag);
    int            key = int'(a);
    bit            oor = (key >> BANK_AW) >= NBANKS;
    int            lat0 = -1, lat1 = -1, glitch = 0;
    logic [15:0]   c0 = '0, c1 = '0, o;
    logic          e0 = 1'b0, e1 = 1'b0;
    we = w; adr = a; sel = s; wdat = d; stb = 1'b1;
    for (int k = 0; k < 40 && (lat0 < 0 || lat1 < 0); k++) begin
      @(negedge clk_p);
      if (lat0 >= 0 && !ack0) glitch++;
      if (ack0 && lat0 < 0) begin lat0 = k; c0 = dat0; e0 = err0; end
      if (ack1 && lat1 < 0) begin lat1 = k; c1 = dat1; e1 = err1; end
      if (k == 0) begin adr = ~a; wdat = ~d; we = ~w; end
    end
    if (w && !oor) begin
      o = mem.exists(key) ? mem[key] : '0;
      if (s[0]) o[7:0]  = d[7:0];
      if (s[1]) o[15:8] = d[15:8];
      mem[key] = o;
    end
    if (!w) last_rd = oor ? 16'h0 : mem[key];
    check({tag, ".lat0"}, lat0, 2);
    check({tag, ".lat1"}, lat1, 2 + (w ? WW1 : RW1));
    check({tag, ".dat0"}, c0, last_rd);
    check({tag, ".dat1"}, c1, last_rd);
    check({tag, ".err0"}, e0, oor);
    check({tag, ".err1"}, e1, oor);
    check({tag, ".hold0"}, glitch, 0);
    stb = 1'b0;
    #1;
    check({tag, ".ackdrop"}, {ack0, ack1}, 2'b00);
    @(negedge clk_p);
  endtask

  task automatic reset_mid(input bit w, input logic [20:0] a, input logic [15:0] d, input string tag);
    int seen1 = 0;
    we = w; adr = a; sel = 2'b11; wdat = d; stb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_p);
      if (ack1) seen1++;
    end
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_p);
      if (ack1) seen1++;
    end
    check({tag, ".ack1"}, seen1, 0);
    check({tag, ".dat"}, {dat0, dat1}, 32'h0);
    check({tag, ".rdy"}, {rdy0, rdy1}, 2'b00);
`ifdef SRAM_INIT_CLEAR_EN
    foreach (mem[k]) mem[k] = '0;
`else
    if (w) mem[int'(a)] = d;
`endif
    last_rd = '0;
    stb = 1'b0;
    rst_n = 1'b1;
    wait_ready(tag);
  endtask

  initial begin
    int pool [8] = '{32'h00000, 32'h0FFFF, 32'h10000, 32'h2ABCD,
                     32'h3FFFF, 32'h4FFFF, 32'h40000, 32'h1234A};
    logic [20:0] a;
    repeat (3) @(negedge clk_p);
    check("rst.ready", {rdy0, rdy1}, 2'b00);
    check("rst.ack", {ack0, ack1}, 2'b00);
    check("rst.dat", {dat0, dat1}, 32'h0);
    check("rst.err", {err0, err1}, 2'b00);
    rst_n = 1'b1;
    wait_ready("rel");

    txn(1, 21'h00010, 2'b11, 16'hA5C3, "t1w");
    txn(0, 21'h00010, 2'b00, 16'h0000, "t1r");
    check("t1.value", last_rd, 16'hA5C3);
    txn(1, 21'h00020, 2'b11, 16'h1234, "t2a");
    txn(1, 21'h00020, 2'b10, 16'hFF00, "t2b");
    txn(0, 21'h00020, 2'b00, 16'h0000, "t2r");
    check("t2.value", last_rd, 16'hFF34);
    txn(1, 21'h00005, 2'b11, 16'h1111, "t3a");
    txn(1, 21'h10005, 2'b11, 16'h2222, "t3b");
    txn(0, 21'h00005, 2'b00, 16'h0000, "t3ra");
    txn(0, 21'h10005, 2'b00, 16'h0000, "t3rb");
    txn(1, 21'h00000, 2'b11, 16'h7777, "t4a");
    txn(0, 21'h50000, 2'b00, 16'h0000, "t4r");
    txn(1, 21'h50000, 2'b11, 16'hDEAD, "t4w");
    txn(0, 21'h00000, 2'b00, 16'h0000, "t4b");
    check("t4.value", last_rd, 16'h7777);

    foreach (pool[i]) txn(1, 21'(pool[i]), 2'b11, 16'($urandom), "init");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = 21'(($urandom_range(NBANKS, 31) << BANK_AW) | $urandom_range(0, 65535));
      else
        a = 21'(pool[$urandom_range(0, 7)]);
      txn(1'($urandom), a, 2'($urandom), 16'($urandom), "rnd");
    end

    reset_mid(0, 21'h10005, 16'h0000, "r6rd");
    reset_mid(1, 21'h00005, 16'hBEEF, "r6wr");
    we = 1'b1; adr = 21'h00010; sel = 2'b11; wdat = 16'h0BAD; stb = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_p);
    stb = 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
    foreach (mem[k]) mem[k] = '0;
`endif
    rst_n = 1'b1;
    wait_ready("r6idle");
    txn(0, 21'h00005, 2'b00, 16'h0000, "r6c1");
    txn(0, 21'h00010, 2'b00, 16'h0000, "r6c2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
